// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode seven-segment digits.
// Double-buffered value; the shadow is applied only at frame wrap so a scan never tears.
module seven_seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lz_en,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  pending,
  output logic                  frame_tick
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] DIG_LAST   = IDX_W'(DIGITS - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [4*DIGITS-1:0]   active;
  logic [4*DIGITS-1:0]   shadow;

  logic                  slot_end;
  logic                  frame_wrap;
  logic                  apply;
  logic [IDX_W-1:0]      idx_next;
  logic [4*DIGITS-1:0]   active_next;
  logic [DIGITS-1:0]     suppress;
  logic [DIGITS-1:0]     show_an;

  assign slot_end    = (state == ST_SHOW) && (cnt == SCAN_LAST);
  assign frame_wrap  = slot_end && (digit_idx == DIG_LAST);
  assign apply       = frame_wrap && pending;
  assign idx_next    = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
  assign active_next = apply ? shadow : active;

  // Digit k>0 goes dark when it and every more-significant digit are zero.
  always_comb begin
    suppress = '0;
    for (int k = 1; k < DIGITS; k++)
      suppress[k] = lz_en && ((active >> (4*k)) == '0);
  end

  always_comb begin
    show_an = '1;
    if (en && !suppress[digit_idx])
      show_an[digit_idx] = 1'b0;
  end

  // NOTE: every register, including the value buffers, clears on the async
  // reset edge so a reset mid-load leaves no stale pending value behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      digit_idx  <= '0;
      nibble     <= 4'h0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let each branch read pre-edge state, which
      // is what gives "active takes old shadow while shadow takes value_in".
      frame_tick <= apply;
      active     <= active_next;
      if (load)
        shadow <= value_in;
      if (apply)
        pending <= load;
      else if (load)
        pending <= 1'b1;

      case (state)
        ST_BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state <= ST_SHOW;
            an    <= show_an;
          end else begin
            an <= '1;
          end
        end
        ST_SHOW: begin
          if (slot_end) begin
            cnt       <= '0;
            state     <= ST_BLANK;
            digit_idx <= idx_next;
            nibble    <= active_next[4*idx_next +: 4];
            an        <= '1;
          end else begin
            cnt <= cnt + 1'b1;
            an  <= show_an;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a frame/slot arithmetic model predicts
// every cycle's outputs, a monitor pops and compares them.
module tb_seven_seg_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [4*DIGITS-1:0]  value_in = '0;
  logic                 load = 1'b0;
  logic                 en = 1'b1;
  logic                 lz_en = 1'b0;
  logic [3:0]           nibble;
  logic [DIGITS-1:0]    an;
  logic [1:0]           digit_idx;
  logic                 pending;
  logic                 frame_tick;

  seven_seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load), .en(en),
    .lz_en(lz_en), .nibble(nibble), .an(an), .digit_idx(digit_idx),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        nibble;
    logic [DIGITS-1:0] an;
    logic [1:0]        idx;
    logic              pending;
    logic              tick;
  } obs_t;

  obs_t exp_q[$];
  int   cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;

  // Reference model: value buffers advanced once per clock edge.
  logic [15:0] m_active, m_shadow;
  bit          m_pend, m_tick;

  function automatic obs_t expect_at(int tc, bit en_p, bit lz_p);
    obs_t e;
    int   pos = tc % SCAN_DIV;
    int   d   = (tc / SCAN_DIV) % DIGITS;
    e.nibble  = m_active[4*d +: 4];
    e.idx     = 2'(d);
    e.pending = m_pend;
    e.tick    = m_tick;
    e.an      = '1;
    if (pos >= BLANK_CYCLES && en_p && !(lz_p && d > 0 && (m_active >> (4*d)) == 16'h0))
      e.an[d] = 1'b0;
    return e;
  endfunction

  task automatic model_edge(bit ld, logic [15:0] v, int tnew);
    m_tick = 1'b0;
    if (tnew % FRAME == 0 && m_pend) begin
      m_active = m_shadow;
      m_tick   = 1'b1;
      m_pend   = 1'b0;
    end
    if (ld) begin
      m_shadow = v;
      m_pend   = 1'b1;
    end
  endtask

  task automatic push_exp(bit en_p, bit lz_p);
    exp_q.push_back(expect_at(t, en_p, lz_p));
    cyc_q.push_back(t);
  endtask

  // Called mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset();
    obs_t r;
    r.nibble = 4'h0; r.an = '1; r.idx = 2'd0; r.pending = 1'b0; r.tick = 1'b0;
    load  = 1'b0;
    reset = 1'b1;
    exp_q.push_back(r);
    cyc_q.push_back(-1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_active = '0; m_shadow = '0; m_pend = 1'b0; m_tick = 1'b0;
    t        = 0;
    push_exp(1'b1, 1'b0);
  endtask

  task automatic step();
    bit          ld  = load;
    logic [15:0] v   = value_in;
    bit          e_c = en;
    bit          l_c = lz_en;
    @(posedge clk);
    #1;
    t = t + 1;
    model_edge(ld, v, t);
    push_exp(e_c, l_c);
    load = 1'b0;
  endtask

  task automatic run_to(int target);
    while (t < target) step();
  endtask

  task automatic load_val(logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    step();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    do_reset();
  endtask

  // Monitor: outputs are sampled 1 time unit after each falling edge, and just
  // after any asynchronous reset assertion.
  initial begin
    obs_t act, e;
    int   c;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      act = {nibble, an, digit_idx, pending, frame_tick};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: DUT output %h with no expectation queued", act);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got nib=%h an=%b idx=%0d pend=%b tick=%b want nib=%h an=%b idx=%0d pend=%b tick=%b",
                   c, act.nibble, act.an, act.idx, act.pending, act.tick,
                   e.nibble, e.an, e.idx, e.pending, e.tick);
        end
      end
    end
  end

  initial begin
    #2 do_reset();

    // Plain scan, then a load early in the first frame applied at cycle 32.
    run_to(5);
    load_val(16'h1234);
    run_to(2*FRAME);

    // Two loads in one frame: only the last one lands; leading zeros suppressed.
    lz_en = 1'b1;
    run_to(2*FRAME + 3);
    load_val(16'hAAAA);
    run_to(2*FRAME + 20);
    load_val(16'h0005);
    run_to(4*FRAME + 4);

    // Load on the exact wrap edge while another value is pending.
    lz_en = 1'b0;
    load_val(16'h1111);
    run_to(5*FRAME - 1);
    load_val(16'h00F0);
    run_to(6*FRAME + 2);

    // Display disabled for the whole slot of digit 2.
    run_to(6*FRAME + 2*SCAN_DIV - 1);
    en = 1'b0;
    run_to(6*FRAME + 3*SCAN_DIV - 1);
    en = 1'b1;
    run_to(7*FRAME + 1);

    // Reset mid-slot with active=1234 and another value pending.
    load_val(16'h1234);
    run_to(8*FRAME + 1);
    load_val(16'h5678);
    run_to(8*FRAME + 13);
    mid_reset();
    run_to(FRAME + 4);

    // Randomized traffic, including loads on wrap edges and rare resets.
    for (int i = 0; i < 2000; i++) begin
      value_in = 16'($urandom);
      load     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0) lz_en = ~lz_en;
      if ((t % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0) load = 1'b1;
      if ($urandom_range(0, 499) == 0) mid_reset();
      else step();
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
